// File: rtl/ibus_sram_responder.sv
// Instruction-bus responder backed by a word-addressed SRAM; fixed LATENCY from accept to data_ok.
// One request in flight; addr_ok is offered in IDLE and in the data_ok cycle for back-to-back accepts.
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_sram_responder
  import ibus_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, stateNext;
  logic [3:0]  counter;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] dataReg;
  logic        errReg;
  logic [29:0] reqWord, initWord;
  logic        reqBad, addrOk, accept;

  // Wrap-around subtraction: addresses below the base land far out of range.
  assign reqWord  = 30'((ireq.addr - BASE_ADDR) >> 2);
  assign initWord = 30'((init_addr - BASE_ADDR) >> 2);
  assign reqBad   = (reqWord >= 30'(MEM_DEPTH)) || (ireq.addr[1:0] != 2'b00);
  assign addrOk   = resetn && ireq.valid && (state == IDLE || state == RESP);
  assign accept   = addrOk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, RESP: begin
        if (accept) stateNext = (LATENCY == 1) ? RESP : WAIT;
        else        stateNext = IDLE;
      end
      WAIT:    if (counter == 4'd1) stateNext = RESP;
      default: stateNext = IDLE;
    endcase
  end

  // The read samples the word before any same-edge init write lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter <= '0;
      dataReg <= '0;
      errReg  <= 1'b0;
    end else if (accept) begin
      counter <= 4'(LATENCY - 1);
      if (reqBad) begin
        dataReg <= '0;
        errReg  <= 1'b1;
      end else begin
        dataReg <= mem[reqWord[AW-1:0]];
        errReg  <= 1'b0;
      end
    end else if (state == WAIT) begin
      counter <= counter - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (init_we && (initWord < 30'(MEM_DEPTH)))
      mem[initWord[AW-1:0]] <= init_data;
  end

  always_comb begin
    iresp.addr_ok = addrOk;
    iresp.data_ok = (state == RESP);
    iresp.data    = dataReg;
    err           = errReg;
    busy          = (state != IDLE);
  end

endmodule
